// File: rtl/dmem_mmio_unit.sv
// rtl/dmem_mmio_unit.sv - word RAM plus 16-word I/O window (GPIO, edge capture, compare timer)
module dmem_mmio_unit #(
  parameter int          RAM_AW    = 12,
  parameter logic [12:0] MMIO_BASE = 13'h1FF0,
  parameter int          TIMER_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] dm_abus,
  input  logic [15:0] dm_in_dbus,
  input  logic        dm_we,
  output logic [15:0] dm_out_dbus,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic        timer_match
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  logic [15:0] ram [RAM_WORDS];

  logic               is_ram, is_io;
  logic [3:0]         off;
  logic               io_we;
  logic               wr_gpio, wr_cnt, wr_cmp, wr_status, wr_edge;

  logic [15:0]        gpio_out_r;
  logic [15:0]        sync1, sync2, prev;
  logic [15:0]        edge_flags;
  logic [15:0]        edge_new;
  logic [TIMER_W-1:0] cnt, cmp, cnt_nxt;
  logic               st_match, st_en, st_ar;
  logic               match_set;
  logic [15:0]        rdata;

  assign is_ram = (dm_abus >> RAM_AW) == 13'd0;
  assign is_io  = !is_ram && (dm_abus[12:4] == MMIO_BASE[12:4]);
  assign off    = dm_abus[3:0];

  assign io_we     = dm_we && is_io;
  assign wr_gpio   = io_we && (off == 4'd0);
  assign wr_cnt    = io_we && (off == 4'd2);
  assign wr_cmp    = io_we && (off == 4'd3);
  assign wr_status = io_we && (off == 4'd4);
  assign wr_edge   = io_we && (off == 4'd5);

  // RAM is not reset; stores are blocked while reset is held low.
  always_ff @(posedge clk) begin
    if (reset && dm_we && is_ram)
      ram[dm_abus[RAM_AW-1:0]] <= dm_in_dbus;
  end

  assign edge_new = sync2 & ~prev;

  // A software load of CNT pre-empts both the increment and the match compare.
  always_comb begin
    cnt_nxt   = cnt;
    match_set = 1'b0;
    if (wr_cnt) begin
      cnt_nxt = dm_in_dbus[TIMER_W-1:0];
    end else if (st_en) begin
      if (cnt == cmp) begin
        match_set = 1'b1;
        cnt_nxt   = st_ar ? '0 : cnt + TIMER_W'(1);
      end else begin
        cnt_nxt   = cnt + TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_r <= '0;
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      edge_flags <= '0;
      cnt        <= '0;
      cmp        <= '0;
      st_match   <= 1'b0;
      st_en      <= 1'b0;
      st_ar      <= 1'b0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
      cnt   <= cnt_nxt;
      if (wr_gpio)
        gpio_out_r <= dm_in_dbus;
      if (wr_cmp)
        cmp <= dm_in_dbus[TIMER_W-1:0];
      if (wr_status) begin
        st_en <= dm_in_dbus[1];
        st_ar <= dm_in_dbus[2];
      end
      // Sticky flags: a new set event beats a same-cycle write-1-clear.
      st_match   <= match_set | (st_match & ~(wr_status & dm_in_dbus[0]));
      edge_flags <= edge_new | (edge_flags & ~({16{wr_edge}} & dm_in_dbus));
    end
  end

  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = ram[dm_abus[RAM_AW-1:0]];
    end else if (is_io) begin
      case (off)
        4'd0:    rdata = gpio_out_r;
        4'd1:    rdata = sync2;
        4'd2:    rdata = 16'(cnt);
        4'd3:    rdata = 16'(cmp);
        4'd4:    rdata = {13'd0, st_ar, st_en, st_match};
        4'd5:    rdata = edge_flags;
        default: rdata = '0;
      endcase
    end
  end

  assign dm_out_dbus = rdata;
  assign gpio_out    = gpio_out_r;
  assign timer_match = st_match;

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// tb/tb_dmem_mmio_unit.sv - scoreboard bench for dmem_mmio_unit
`timescale 1ns/100ps
module tb_dmem_mmio_unit;

  logic        clk;
  logic        reset;
  logic [12:0] dm_abus;
  logic [15:0] dm_in_dbus;
  logic        dm_we;
  logic [15:0] dm_out_dbus;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        timer_match;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  localparam logic [12:0] A_GPIO = 13'h1FF0;
  localparam logic [12:0] A_GIN  = 13'h1FF1;
  localparam logic [12:0] A_CNT  = 13'h1FF2;
  localparam logic [12:0] A_CMP  = 13'h1FF3;
  localparam logic [12:0] A_STAT = 13'h1FF4;
  localparam logic [12:0] A_EDGE = 13'h1FF5;

  dmem_mmio_unit dut (
    .clk         (clk),
    .reset       (reset),
    .dm_abus     (dm_abus),
    .dm_in_dbus  (dm_in_dbus),
    .dm_we       (dm_we),
    .dm_out_dbus (dm_out_dbus),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .timer_match (timer_match)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [12:0] addr, input logic [15:0] data);
    dm_abus    = addr;
    dm_in_dbus = data;
    dm_we      = 1'b1;
    tick();
    dm_we      = 1'b0;
  endtask

  task automatic rd(input logic [12:0] addr, input logic [15:0] exp, input string tag);
    exp_q.push_back(exp);
    dm_abus = addr;
    #1;
    check_eq(tag, dm_out_dbus, exp_q.pop_front());
  endtask

  initial begin
    reset      = 1'b0;
    dm_abus    = '0;
    dm_in_dbus = '0;
    dm_we      = 1'b0;
    gpio_in    = '0;
    tick();
    check_eq("rst_gpio_out", gpio_out, 16'h0000);
    check_eq("rst_match", {15'd0, timer_match}, 16'h0000);
    tick();
    reset = 1'b1;
    rd(A_STAT, 16'h0000, "rst_status");
    rd(A_CNT, 16'h0000, "rst_cnt");

    // RAM: same-cycle read of a stored word returns the old value
    wr(13'h0005, 16'h1111);
    dm_abus    = 13'h0005;
    dm_in_dbus = 16'hBEEF;
    dm_we      = 1'b1;
    rd(13'h0005, 16'h1111, "ram_old");
    tick();
    dm_we = 1'b0;
    rd(13'h0005, 16'hBEEF, "ram_new");
    rd(13'h1000, 16'h0000, "unmapped_rd");
    wr(13'h1000, 16'h1234);
    rd(13'h1000, 16'h0000, "unmapped_wr");
    rd(13'h0005, 16'hBEEF, "ram_keep");
    check_eq("unmapped_gpio", gpio_out, 16'h0000);
    tick();
    rd(13'h1FFF, 16'h0000, "io_off15");

    // GPIO and edge capture
    wr(A_GPIO, 16'h00A5);
    check_eq("gpio_out", gpio_out, 16'h00A5);
    rd(A_GPIO, 16'h00A5, "gpio_rd");
    gpio_in = 16'h0003;
    tick();
    rd(A_GIN, 16'h0000, "gin_lat1");
    tick();
    rd(A_GIN, 16'h0003, "gin_lat2");
    rd(A_EDGE, 16'h0000, "edge_early");
    tick();
    rd(A_EDGE, 16'h0003, "edge_set");
    wr(A_EDGE, 16'h0001);
    rd(A_EDGE, 16'h0002, "edge_clr");
    wr(A_GIN, 16'hFFFF);
    rd(A_GIN, 16'h0003, "gin_ro");

    // Timer one-shot
    wr(A_CMP, 16'h0004);
    wr(A_CNT, 16'h0000);
    wr(A_STAT, 16'h0002);
    for (int i = 0; i < 6; i++) begin
      rd(A_CNT, 16'(i), $sformatf("os_cnt%0d", i));
      check_eq($sformatf("os_match%0d", i), {15'd0, timer_match}, (i >= 5) ? 16'h1 : 16'h0);
      tick();
    end
    wr(A_CNT, 16'hFFFE);
    rd(A_CNT, 16'hFFFE, "wrap_a");
    tick();
    rd(A_CNT, 16'hFFFF, "wrap_b");
    tick();
    rd(A_CNT, 16'h0000, "wrap_c");
    rd(A_STAT, 16'h0003, "os_status");
    wr(A_STAT, 16'h0001);
    rd(A_STAT, 16'h0000, "match_clr");
    check_eq("match_clr_pin", {15'd0, timer_match}, 16'h0000);

    // Timer autoreload
    wr(A_CMP, 16'h0002);
    wr(A_CNT, 16'h0000);
    wr(A_STAT, 16'h0006);
    for (int i = 0; i < 5; i++) begin
      rd(A_CNT, 16'(i % 3), $sformatf("ar_cnt%0d", i));
      check_eq($sformatf("ar_match%0d", i), {15'd0, timer_match}, (i >= 3) ? 16'h1 : 16'h0);
      tick();
    end
    wr(A_STAT, 16'h0007);
    rd(A_STAT, 16'h0007, "set_wins");
    rd(A_CNT, 16'h0000, "ar_reload");
    wr(A_STAT, 16'h0007);
    rd(A_STAT, 16'h0006, "ar_clr");
    check_eq("ar_clr_pin", {15'd0, timer_match}, 16'h0000);
    rd(A_CNT, 16'h0001, "ar_cnt_after");
    tick();

    // CNT write collides with a match cycle
    wr(A_CNT, 16'h0100);
    rd(A_CNT, 16'h0100, "coll_cnt");
    rd(A_STAT, 16'h0006, "coll_nomatch");
    tick();
    rd(A_CNT, 16'h0101, "coll_inc");

    // Async reset mid-cycle
    wr(A_CNT, 16'h0002);
    tick();
    check_eq("pre_rst_match", {15'd0, timer_match}, 16'h0001);
    reset = 1'b0;
    #2;
    check_eq("arst_gpio", gpio_out, 16'h0000);
    check_eq("arst_match", {15'd0, timer_match}, 16'h0000);
    rd(A_CNT, 16'h0000, "arst_cnt");
    rd(A_STAT, 16'h0000, "arst_status");
    wr(13'h0005, 16'h0000);
    tick();
    reset = 1'b1;
    rd(13'h0005, 16'hBEEF, "ram_survives");
    tick();
    tick();
    rd(A_GIN, 16'h0003, "post_rst_gin");
    tick();
    rd(A_EDGE, 16'h0003, "post_rst_edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_unit.md
Name: dmem_mmio_unit

Overview:
- Data-memory stage that sits directly on the accumulator datapath's data bus. It consumes dm_abus/dm_in_dbus plus the controller's store strobe and returns dm_out_dbus within the same cycle.
- Holds word RAM and a small memory-mapped I/O window: GPIO out, synchronized GPIO in with edge capture, and a compare timer. Programs use it through ordinary load/store instructions.

Parameters:
- RAM_AW, 12, RAM address width; RAM occupies 0x0000..(2^RAM_AW-1), 4096 words by default.
- MMIO_BASE, 13'h1FF0, base of the 16-word I/O window; MMIO_BASE[3:0] must be 0.
- TIMER_W, 16, timer counter/compare width (≤16, zero-extended on read).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- dm_abus  in  13  word address from datapath
- dm_in_dbus  in  16  store data (accumulator value)
- dm_we  in  1  store strobe from controller, sampled at clk rising edge
- dm_out_dbus  out  16  load data, combinational from dm_abus
- gpio_in  in  16  asynchronous external inputs
- gpio_out  out  16  output port register
- timer_match  out  1  level copy of STATUS.match

Behaviour:
- Reset (reset=0, asynchronous): all I/O registers, synchronizers and the timer go to 0. gpio_out=0, timer_match=0. RAM contents are not reset.
- Reads are combinational, with zero latency: dm_out_dbus follows dm_abus in the same cycle, as the single-cycle CPU requires.
- Writes occur at the clk edge when dm_we=1.
- A read of the address being written in that cycle returns the old value.
- Address decode:
  - RAM when dm_abus < 2^RAM_AW.
  - I/O when dm_abus[12:4]==MMIO_BASE[12:4].
  - Otherwise unmapped: read 0, write ignored.
- I/O map (offset: register):
  - 0 GPIO_OUT: RW, drives gpio_out.
  - 1 GPIO_IN: RO, value after a 2-flop synchronizer, so 2-cycle latency from a pin change.
  - 2 TIMER_CNT: RW; a write loads the counter.
  - 3 TIMER_CMP: RW.
  - 4 STATUS:
    - bit0 match: sticky; write 1 clears it.
    - bit1 enable: RW.
    - bit2 autoreload: RW.
    - Other bits read 0.
  - 5 EDGE: sticky rising-edge flags per gpio_in bit; write 1 clears the corresponding bit.
  - 6..15: read 0, writes ignored.
  - Writes to RO offsets are ignored.
- Timer, evaluated each cycle while enable=1:
  - If CNT==CMP: match sets; next CNT = 0 if autoreload, else CNT+1.
  - Otherwise CNT increments, wrapping 2^TIMER_W-1 → 0.
  - While enable=0, CNT holds and no match is generated.
- Edge capture: edge[i] = sync[i] & ~prev[i], where prev is the previous synchronized value. EDGE[i] is set one cycle after a rising edge appears on sync[i].
  - Because prev resets to 0, an input already high at reset release records one edge.
- Simultaneous events:
  - Software write to TIMER_CNT in the same cycle as an increment or reload: the write wins, and no match is evaluated that cycle.
  - Write-1-clear of match/EDGE in the same cycle as a new set event: set wins.
  - Write to STATUS with bit0=1 and a new enable value: enable updates, and the match clear follows the rule above.
- Reset asserted mid-operation clears everything at once, independent of clk. dm_we is ignored while reset=0.

Test Plan:
- RAM access: store 0xBEEF to 0x0005 (dm_we=1 for one cycle) → same-cycle read returns the old value; next cycle dm_out_dbus=0xBEEF. Read 0x1000 → 0x0000; a store to 0x1000 leaves all state unchanged.
- GPIO: write 0x00A5 to 0x1FF0 → gpio_out=0x00A5 after the edge. Drive gpio_in=0x0003 → GPIO_IN reads 0x0003 exactly 2 cycles later; EDGE=0x0003 the cycle after that. Write 0x0001 to EDGE → reads 0x0002.
- Timer one-shot: CMP=4, CNT=0, STATUS=0x2 → CNT steps 0,1,2,3,4 then 5; match and timer_match rise after the CNT==4 cycle and stay set while CNT continues to 0xFFFF→0.
- Timer autoreload: CMP=2, STATUS=0x6 → CNT sequence 0,1,2,0,1,2…; match sets at the first wrap. A write of STATUS=0x7 in a cycle where CNT==CMP leaves match=1 (set wins).
- Collision: write CNT=0x0100 in the same cycle the timer would increment → CNT=0x0100 next cycle, then 0x0101.
- Async reset: pull reset low mid-count between clk edges → gpio_out, CNT, STATUS and timer_match read 0 immediately; RAM word 0x0005 still reads 0xBEEF after release.
